// File: rtl/key_debounce.sv
// key_debounce: synchronises one active-low key pin, debounces it with a
// four-state qualifier FSM and produces a clean level plus registered
// press / release / long-press pulses.
module key_debounce #(
    parameter int DB_CYC   = 1_000_000,
    parameter int LONG_CYC = 50_000_000,
    parameter int CNT_W    = 20,
    parameter int HOLD_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t            state;
    logic              s1;
    logic              key_s;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hcnt;

    // Two-flop synchroniser; resets to "released" so a held key is re-qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            key_s <= 1'b1;
        end else begin
            s1    <= key_n;
            key_s <= s1;
        end
    end

    // Qualifier FSM with debounce/hold counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hcnt        <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    if (!key_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    hcnt <= '0;
                    if (key_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= PRESSED;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                    // Saturating at LONG_CYC makes the long pulse one-shot per press.
                    if (hcnt == HOLD_LAST) begin
                        key_long <= 1'b1;
                        hcnt     <= HOLD_SAT;
                    end else if (hcnt != HOLD_SAT) begin
                        hcnt <= hcnt + HOLD_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    // hcnt is held here so a release bounce does not restart the hold timer.
                    if (!key_s) begin
                        state <= PRESSED;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    hcnt      <= '0;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus random key waveforms, every cycle
// compared against a run-length reference model of the debouncer.
module tb_key_debounce;

    localparam int DB = 4;
    localparam int LC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_n = 1'b1;
    logic key_level, key_press, key_release, key_long;

    int checks = 0;
    int errors = 0;

    key_debounce #(.DB_CYC(DB), .LONG_CYC(LC), .CNT_W(3), .HOLD_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    // Reference model: a change is accepted after DB+1 consecutive edges on
    // which the synchronised key disagrees with the accepted level; the long
    // pulse fires on the LC-th edge spent pressed with no pending disagreement.
    bit m_s1, m_ks, m_level, m_press, m_rel, m_long, m_done;
    int m_run, m_hold;

    function automatic void model_reset();
        m_s1 = 1; m_ks = 1; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
        m_done = 0; m_run = 0; m_hold = 0;
    endfunction

    function automatic void model_edge(bit kn);
        bit ks;
        bit steady_pressed;
        ks = m_ks;
        m_ks = m_s1;
        m_s1 = kn;
        steady_pressed = m_level && (m_run == 0);
        m_press = 0; m_rel = 0; m_long = 0;
        if (steady_pressed) begin
            m_hold++;
            if (m_hold == LC && !m_done) begin
                m_long = 1;
                m_done = 1;
            end
        end
        if ((!ks) != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = !m_level;
                m_run = 0;
                if (m_level) begin
                    m_press = 1; m_hold = 0; m_done = 0;
                end else begin
                    m_rel = 1;
                end
            end
        end else begin
            m_run = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive key, advance model on the edge, compare just after it.
    task automatic step(input bit kn);
        key_n = kn;
        @(posedge clk);
        if (rst_n) model_edge(kn);
        #1;
        chk("cycle", {key_level, key_press, key_release, key_long},
            {m_level, m_press, m_rel, m_long});
    endtask

    initial begin
        int at, at2, n;
        bit kn;
        model_reset();

        // Reset held with key pressed: everything stays low.
        rst_n = 0; key_n = 0;
        repeat (3) step(0);
        rst_n = 1;
        at = -1; n = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0);
            if (key_press) begin n++; if (at < 0) at = i; end
        end
        chk_int("rst_press_edge", at, 7);
        chk_int("rst_press_count", n, 1);
        repeat (10) step(1);

        // Clean press then release.
        at = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0);
            if (key_press && at < 0) at = i;
        end
        chk_int("press_latency", at, 7);
        at = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (key_release && at < 0) at = i;
        end
        chk_int("release_latency", at, 7);
        chk_int("level_after_release", int'(key_level), 0);

        // Press bounce 0,0,1,0,1 then steady low.
        step(0); step(0); step(1); step(0); step(1);
        at = -1; n = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0);
            if (key_press) begin n++; if (at < 0) at = i; end
        end
        chk_int("bounce_press_edge", at, 7);
        chk_int("bounce_press_count", n, 1);

        // Release bounce: 2 cycles high then low; long pulse delayed by the held cycles.
        n = 0;
        step(1); step(1);
        for (int i = 0; i < 20; i++) begin
            step(0);
            if (key_press || key_release || !key_level) n++;
        end
        chk_int("release_bounce_quiet", n, 0);
        repeat (12) step(1);

        // Long press, twice.
        for (int r = 0; r < 2; r++) begin
            at = -1; at2 = -1; n = 0;
            for (int i = 1; i <= 40; i++) begin
                step(0);
                if (key_press && at < 0) at = i;
                if (key_long) begin n++; if (at2 < 0) at2 = i; end
            end
            chk_int("long_latency", at2 - at, LC);
            chk_int("long_count", n, 1);
            repeat (12) step(1);
        end

        // Reset in PRESSED: level drops at once, no release pulse afterwards.
        repeat (10) step(0);
        chk_int("pressed_before_rst", int'(key_level), 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("async_rst", {key_level, key_press, key_release, key_long}, 4'b0000);
        repeat (2) step(1);
        rst_n = 1;
        repeat (12) step(1);

        // Random waveforms: bounces, short and long holds.
        kn = 1;
        for (int s = 0; s < 120; s++) begin
            kn = !kn;
            case ($urandom_range(2, 0))
                0: n = $urandom_range(DB, 1);
                1: n = $urandom_range(DB + 8, DB + 1);
                default: n = $urandom_range(LC + 20, LC);
            endcase
            repeat (n) step(kn);
        end
        repeat (15) step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
